// File: rtl/if_fetch_stage_pkg.sv
// Shared constants, encodings and helpers for the instruction-fetch stage.
package if_fetch_stage_pkg;

  localparam int unsigned INST_ADDR_W = 32;
  localparam int unsigned INST_W      = 32;

  localparam logic [INST_W-1:0] ZERO_WORD = '0;

  // Bit positions inside the pipeline stall vector.
  localparam int unsigned STALL_PC_BIT = 0;
  localparam int unsigned STALL_IF_BIT = 1;
  localparam int unsigned STALL_ID_BIT = 2;

  // Exception flag raised when the fetch address is not word aligned.
  localparam int unsigned EXC_MISALIGNED_BIT = 13;

  typedef enum logic {
    CHIP_DISABLE = 1'b0,
    CHIP_ENABLE  = 1'b1
  } chip_en_e;

  typedef enum logic {
    NO_STOP = 1'b0,
    STOP    = 1'b1
  } stop_e;

  // Source selected for the next program counter value.
  typedef enum logic [2:0] {
    PC_SRC_RESET,
    PC_SRC_FLUSH,
    PC_SRC_HOLD,
    PC_SRC_BRANCH,
    PC_SRC_SEQ
  } pc_src_e;

  // Action taken by the IF/ID pipeline register on an edge.
  typedef enum logic [1:0] {
    IFID_CLEAR,
    IFID_BUBBLE,
    IFID_LOAD,
    IFID_HOLD
  } ifid_op_e;

  function automatic logic fetch_misaligned(input logic [INST_ADDR_W-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

  // Exception flags for a fetch at addr; only meaningful while the ROM is enabled.
  function automatic logic [31:0] fetch_excepttype(input logic ce,
                                                   input logic [INST_ADDR_W-1:0] addr);
    logic [31:0] exc;
    exc = '0;
    exc[EXC_MISALIGNED_BIT] = ce && fetch_misaligned(addr);
    return exc;
  endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction ROM bus: fetch address and chip enable out, instruction word back.
interface if_fetch_stage_if;
  import if_fetch_stage_pkg::*;

  logic [INST_ADDR_W-1:0] pc;
  logic                   ce;
  logic [INST_W-1:0]      inst_i;

  modport master (
    output pc,
    output ce,
    input  inst_i
  );

  modport slave (
    input  pc,
    input  ce,
    output inst_i
  );

endinterface

// File: rtl/if_fetch_stage_pc_reg.sv
// Program counter and ROM chip-enable with the redirect/stall priority chain.
module pc_reg
  import if_fetch_stage_pkg::*;
#(
  parameter logic [INST_ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_pc,
  input  logic                   flush,
  input  logic [INST_ADDR_W-1:0] new_pc,
  input  logic                   branch_flag_i,
  input  logic [INST_ADDR_W-1:0] branch_target_address_i,
  output logic [INST_ADDR_W-1:0] pc,
  output logic                   ce
);

  chip_en_e               ce_q;
  pc_src_e                pc_src;
  logic [INST_ADDR_W-1:0] pc_q;

  // Chip enable rises on the first edge after reset release and stays up.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ce_q <= CHIP_DISABLE;
    end else begin
      ce_q <= CHIP_ENABLE;
    end
  end

  // Next-PC source selection, first match wins; flush beats stall beats branch.
  always_comb begin
    pc_src = PC_SRC_SEQ;
    if (ce_q == CHIP_DISABLE) begin
      pc_src = PC_SRC_RESET;
    end else if (flush) begin
      pc_src = PC_SRC_FLUSH;
    end else if (stall_pc == STOP) begin
      pc_src = PC_SRC_HOLD;
    end else if (branch_flag_i) begin
      pc_src = PC_SRC_BRANCH;
    end
  end

  // Program counter register; sequential increment wraps at 32 bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= RESET_PC;
    end else begin
      unique case (pc_src)
        PC_SRC_RESET:  pc_q <= RESET_PC;
        PC_SRC_FLUSH:  pc_q <= new_pc;
        PC_SRC_HOLD:   pc_q <= pc_q;
        PC_SRC_BRANCH: pc_q <= branch_target_address_i;
        default:       pc_q <= pc_q + INST_ADDR_W'(4);
      endcase
    end
  end

  assign pc = pc_q;
  assign ce = (ce_q == CHIP_ENABLE);

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC/ROM driver plus IF/ID register with misalignment flagging.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [INST_ADDR_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned            STALL_W  = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [STALL_W-1:0]     stall,
  input  logic                   flush,
  input  logic [INST_ADDR_W-1:0] new_pc,
  input  logic                   branch_flag_i,
  input  logic [INST_ADDR_W-1:0] branch_target_address_i,
  if_fetch_stage_if.master       rom,
  output logic [INST_ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0]      id_inst,
  output logic [31:0]            id_excepttype
);

  logic [INST_ADDR_W-1:0] pc;
  logic                   ce;
  logic [INST_W-1:0]      fetch_inst;
  logic [31:0]            fetch_exc;
  ifid_op_e               ifid_op;
  logic                   stall_unused;

  // Stall bits above ID belong to later stages.
  assign stall_unused = ^stall;

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk                     (clk),
    .rst                     (rst),
    .stall_pc                (stall[STALL_PC_BIT]),
    .flush                   (flush),
    .new_pc                  (new_pc),
    .branch_flag_i           (branch_flag_i),
    .branch_target_address_i (branch_target_address_i),
    .pc                      (pc),
    .ce                      (ce)
  );

  assign rom.pc = pc;
  assign rom.ce = ce;

  // Word forwarded to decode: zero while disabled, and zero for a misaligned
  // fetch so the exception path sees a NOP alongside the flag.
  always_comb begin
    fetch_exc  = fetch_excepttype(ce, pc);
    fetch_inst = ZERO_WORD;
    if (ce && !fetch_exc[EXC_MISALIGNED_BIT]) begin
      fetch_inst = rom.inst_i;
    end
  end

  // IF/ID action select, first match wins.
  always_comb begin
    ifid_op = IFID_HOLD;
    if (flush) begin
      ifid_op = IFID_CLEAR;
    end else if (stall[STALL_IF_BIT] == STOP && stall[STALL_ID_BIT] == NO_STOP) begin
      ifid_op = IFID_BUBBLE;
    end else if (stall[STALL_IF_BIT] == NO_STOP) begin
      ifid_op = IFID_LOAD;
    end
  end

  // IF/ID pipeline register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_pc         <= ZERO_WORD;
      id_inst       <= ZERO_WORD;
      id_excepttype <= '0;
    end else begin
      unique case (ifid_op)
        IFID_CLEAR, IFID_BUBBLE: begin
          id_pc         <= ZERO_WORD;
          id_inst       <= ZERO_WORD;
          id_excepttype <= '0;
        end
        IFID_LOAD: begin
          id_pc         <= pc;
          id_inst       <= fetch_inst;
          id_excepttype <= fetch_exc;
        end
        default: begin
          id_pc         <= id_pc;
          id_inst       <= id_inst;
          id_excepttype <= id_excepttype;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for the instruction-fetch stage with a combinational ROM model.
module tb_if_fetch_stage;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        branch_flag_i;
  logic [31:0] branch_target_address_i;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic [31:0] id_excepttype;

  int unsigned n_cmp;
  int unsigned n_err;

  if_fetch_stage_if rom_bus ();

  // ROM word at address A is {16'hC0DE, A[17:2]}; zero while disabled.
  assign rom_bus.inst_i = rom_bus.ce ? {16'hC0DE, rom_bus.pc[17:2]} : 32'h0;

  if_fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .STALL_W  (6)
  ) dut (
    .clk                     (clk),
    .rst                     (rst),
    .stall                   (stall),
    .flush                   (flush),
    .new_pc                  (new_pc),
    .branch_flag_i           (branch_flag_i),
    .branch_target_address_i (branch_target_address_i),
    .rom                     (rom_bus),
    .id_pc                   (id_pc),
    .id_inst                 (id_inst),
    .id_excepttype           (id_excepttype)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_idpc,
                           input logic [31:0] e_inst, input logic [31:0] e_exc);
    check({tag, ".pc"}, rom_bus.pc, e_pc);
    check({tag, ".id_pc"}, id_pc, e_idpc);
    check({tag, ".id_inst"}, id_inst, e_inst);
    check({tag, ".id_exc"}, id_excepttype, e_exc);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b0;
    stall = '0;
    flush = 1'b0;
    new_pc = '0;
    branch_flag_i = 1'b0;
    branch_target_address_i = '0;

    // Held in reset across clock edges.
    step();
    step();
    check("rst.ce", {31'b0, rom_bus.ce}, 32'h0);
    check_all("rst", 32'h0, 32'h0, 32'h0, 32'h0);

    // Release: ce rises on the first edge, PC still at reset value.
    rst = 1'b1;
    step();
    check("rel1.ce", {31'b0, rom_bus.ce}, 32'h1);
    check_all("rel1", 32'h0, 32'h0, 32'h0, 32'h0);
    step();
    check_all("rel2", 32'h4, 32'h0, 32'hC0DE_0000, 32'h0);
    step();
    check_all("rel3", 32'h8, 32'h4, 32'hC0DE_0001, 32'h0);

    // Branch at 0x8 reaches ID; ID asserts it once the delay slot 0xC is fetched.
    step();
    check_all("dslot", 32'hC, 32'h8, 32'hC0DE_0002, 32'h0);
    branch_flag_i = 1'b1;
    branch_target_address_i = 32'h40;
    step();
    check_all("br40", 32'h40, 32'hC, 32'hC0DE_0003, 32'h0);
    branch_flag_i = 1'b0;
    step();
    check_all("br40+1", 32'h44, 32'h40, 32'hC0DE_0010, 32'h0);

    // Branch to 0x10 to set up the stall tests.
    branch_flag_i = 1'b1;
    branch_target_address_i = 32'h10;
    step();
    check_all("br10", 32'h10, 32'h44, 32'hC0DE_0011, 32'h0);
    branch_flag_i = 1'b0;

    // Full stall of PC, IF and ID for two cycles: everything holds.
    stall = 6'b000111;
    step();
    check_all("stall1", 32'h10, 32'h44, 32'hC0DE_0011, 32'h0);
    step();
    check_all("stall2", 32'h10, 32'h44, 32'hC0DE_0011, 32'h0);
    stall = 6'b000000;
    step();
    check_all("resume", 32'h14, 32'h10, 32'hC0DE_0004, 32'h0);

    // IF stalled with ID running: bubble into decode, PC holds.
    stall = 6'b000011;
    step();
    check_all("bubble", 32'h14, 32'h0, 32'h0, 32'h0);
    stall = 6'b000000;
    step();
    check_all("postbub", 32'h18, 32'h14, 32'hC0DE_0005, 32'h0);

    // Flush wins over PC stall and branch; IF/ID cleared.
    flush = 1'b1;
    new_pc = 32'h20;
    stall = 6'b000001;
    branch_flag_i = 1'b1;
    branch_target_address_i = 32'h80;
    step();
    check_all("flush", 32'h20, 32'h0, 32'h0, 32'h0);
    flush = 1'b0;
    stall = 6'b000000;
    branch_flag_i = 1'b0;
    step();
    check_all("postfl", 32'h24, 32'h20, 32'hC0DE_0008, 32'h0);

    // Misaligned target: forwarded with NOP and the misaligned flag; PC not corrected.
    branch_flag_i = 1'b1;
    branch_target_address_i = 32'h42;
    step();
    check_all("br42", 32'h42, 32'h24, 32'hC0DE_0009, 32'h0);
    branch_flag_i = 1'b0;
    step();
    check_all("mis", 32'h46, 32'h42, 32'h0, 32'h0000_2000);

    // Sequential increment wraps at the top of the address space.
    flush = 1'b1;
    new_pc = 32'hFFFF_FFFC;
    step();
    check_all("fltop", 32'hFFFF_FFFC, 32'h0, 32'h0, 32'h0);
    flush = 1'b0;
    step();
    check_all("wrap", 32'h0, 32'hFFFF_FFFC, 32'hC0DE_FFFF, 32'h0);
    step();
    check_all("wrap+1", 32'h4, 32'h0, 32'hC0DE_0000, 32'h0);

    // Asynchronous reset mid-run, sampled before any clock edge.
    #2;
    rst = 1'b0;
    #1;
    check("arst.ce", {31'b0, rom_bus.ce}, 32'h0);
    check("arst.inst_i", rom_bus.inst_i, 32'h0);
    check_all("arst", 32'h0, 32'h0, 32'h0, 32'h0);
    step();
    check("arst2.ce", {31'b0, rom_bus.ce}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
